// File: rtl/siso_frame_ctrl_pkg.sv
// Shared types and constants for the SISO frame controller.
// The bench imports the same state encoding to probe the FSM.
package siso_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must reach WIDTH+DEPTH without wrapping.
  function automatic int unsigned cnt_bits(input int unsigned w, input int unsigned d);
    return $clog2(w + d + 1);
  endfunction

endpackage

// File: rtl/siso_frame_ctrl_if.sv
// Producer/consumer handshakes plus the serial link to the SISO chain.
interface siso_frame_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_match;

  modport slave (
    input  in_valid, in_data, ser_in, out_ready,
    output in_ready, shift_en, ser_out, out_valid, out_data, out_match
  );

  modport master (
    output in_valid, in_data, ser_in, out_ready,
    input  in_ready, shift_en, ser_out, out_valid, out_data, out_match
  );
endinterface

// File: rtl/siso_frame_ctrl_bit_counter.sv
// Frame bit counter: sync clear, enable, terminal flag at TERM.
module siso_bit_counter #(
  parameter int unsigned TERM = 11,
  parameter int unsigned CW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          term_c
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign term_c = (cnt_q == CW'(TERM));

endmodule

// File: rtl/siso_frame_ctrl.sv
// Serializes a word MSB-first into an external SISO chain, flushes it,
// recaptures the word from the chain output and flags whether it matches.
module siso_frame_ctrl
  import siso_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  siso_frame_ctrl_if.slave   bus
);

  localparam int unsigned TERM = WIDTH + DEPTH - 1;
  localparam int unsigned CW   = cnt_bits(WIDTH, DEPTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] gold_q, gold_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_match_q, out_match_d;
  logic             in_ready_q, in_ready_d;
  logic             shift_en_q, shift_en_d;
  logic             ser_out_q, ser_out_d;
  logic             out_valid_q, out_valid_d;

  logic [CW-1:0]    cnt;
  logic             term_c;
  logic             accept_c;
  logic             capture_c;

  assign accept_c  = (state_q == IDLE) && bus.in_valid;
  // Chain output only carries this frame's bits after DEPTH shifts.
  assign capture_c = (cnt >= CW'(DEPTH));

  siso_bit_counter #(
    .TERM (TERM),
    .CW   (CW)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept_c),
    .en     (state_q == SHIFT),
    .cnt    (cnt),
    .term_c (term_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)      state_d = SHIFT;
      SHIFT:   if (term_c)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs are registered one cycle ahead from the next state.
  always_comb begin
    tx_d        = tx_q;
    gold_d      = gold_q;
    rx_d        = rx_q;
    out_data_d  = out_data_q;
    out_match_d = out_match_q;
    ser_out_d   = 1'b0;
    in_ready_d  = (state_d == IDLE);
    shift_en_d  = (state_d == SHIFT);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          tx_d      = bus.in_data << 1;
          gold_d    = bus.in_data;
          rx_d      = '0;
          ser_out_d = bus.in_data[WIDTH-1];
        end
      end
      SHIFT: begin
        // tx empties to zero after WIDTH shifts, giving the flush bits.
        tx_d      = tx_q << 1;
        ser_out_d = tx_q[WIDTH-1];
        if (capture_c) rx_d = WIDTH'({rx_q, bus.ser_in});
        if (term_c) begin
          out_data_d  = rx_d;
          out_match_d = (rx_d == gold_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q        <= '0;
      gold_q      <= '0;
      rx_q        <= '0;
      out_data_q  <= '0;
      out_match_q <= 1'b0;
      in_ready_q  <= 1'b1;
      shift_en_q  <= 1'b0;
      ser_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      gold_q      <= gold_d;
      rx_q        <= rx_d;
      out_data_q  <= out_data_d;
      out_match_q <= out_match_d;
      in_ready_q  <= in_ready_d;
      shift_en_q  <= shift_en_d;
      ser_out_q   <= ser_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.shift_en  = shift_en_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_match = out_match_q;

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Bench for siso_frame_ctrl: an 8x4 and a 1x1 instance, each looped back
// through its own SISO chain, checked against frame-level expectations.
module tb_siso_frame_ctrl;
  import siso_frame_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  siso_frame_ctrl_if #(.WIDTH(8)) a();
  siso_frame_ctrl_if #(.WIDTH(1)) b();

  siso_frame_ctrl #(.WIDTH(8), .DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  siso_frame_ctrl #(.WIDTH(1), .DEPTH(1)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));

  // External SISO chains; never reset, so stale bits survive a controller reset.
  logic [3:0] chain_a = 4'h0;
  logic       chain_b = 1'b0;
  bit         fault_a = 1'b0;
  bit         fault_b = 1'b0;
  always @(posedge clk) if (a.shift_en) chain_a <= {chain_a[2:0], a.ser_out};
  always @(posedge clk) if (b.shift_en) chain_b <= b.ser_out;
  assign a.ser_in = fault_a ? 1'b0 : chain_a[3];
  assign b.ser_in = fault_b ? 1'b0 : chain_b;

  int         cyc = 0;
  int         acc_a[$], acc_b[$];
  logic [7:0] outd_a[$];
  logic       outd_b[$];
  bit         outm_a[$], outm_b[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a.in_valid && a.in_ready) acc_a.push_back(cyc);
    if (b.in_valid && b.in_ready) acc_b.push_back(cyc);
    if (a.out_valid && a.out_ready) begin outd_a.push_back(a.out_data); outm_a.push_back(a.out_match); end
    if (b.out_valid && b.out_ready) begin outd_b.push_back(b.out_data); outm_b.push_back(b.out_match); end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] word;
    bit         flt;
    int         stall;
    logic [7:0] exp_data;
    bit         exp_match;
  } vec_t;

  // One full frame on the 8x4 instance; all expectations come from the caller.
  task automatic send_a(input logic [7:0] w, input bit flt, input int stall,
                        input logic [7:0] exp_d, input bit exp_m);
    int n, t;
    logic [11:0] seq;
    bit busy_ok, hold_ok;
    t = 0;
    while (!a.in_ready && t < 50) begin @(negedge clk); t++; end
    chk("a_ready_before_frame", a.in_ready, 1);
    a.in_valid = 1'b1; a.in_data = w; fault_a = flt;
    @(negedge clk);
    a.in_valid = 1'b0;
    n = 0; seq = '0; busy_ok = 1'b1;
    while (a.shift_en && n < 40) begin
      seq = {seq[10:0], a.ser_out};
      if (a.in_ready || a.out_valid) busy_ok = 1'b0;
      a.in_valid = 1'($urandom_range(0, 1));
      a.in_data  = 8'($urandom);
      n++;
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    chk("a_shift_cycles", n, 12);
    chk("a_ser_out_seq", seq, {w, 4'h0});
    chk("a_busy_flags", busy_ok, 1);
    chk("a_out_valid", a.out_valid, 1);
    chk("a_done_shift_en", a.shift_en, 0);
    chk("a_out_data", a.out_data, exp_d);
    chk("a_out_match", a.out_match, exp_m);
    a.out_ready = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      a.in_valid = 1'b1; a.in_data = 8'($urandom);
      @(negedge clk);
      if (!a.out_valid || a.in_ready || a.out_data !== exp_d || a.out_match !== exp_m ||
          dut_a.state_q != DONE) hold_ok = 1'b0;
    end
    a.in_valid = 1'b0;
    if (stall > 0) chk("a_backpressure_hold", hold_ok, 1);
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0; fault_a = 1'b0;
    chk("a_back_to_idle_ready", a.in_ready, 1);
    chk("a_back_to_idle_valid", a.out_valid, 0);
    chk("a_state_idle", 32'(dut_a.state_q), 32'(IDLE));
  endtask

  task automatic send_b(input logic w, input bit flt);
    int n, t;
    logic [1:0] seq;
    logic ed;
    t = 0;
    while (!b.in_ready && t < 20) begin @(negedge clk); t++; end
    chk("b_ready_before_frame", b.in_ready, 1);
    b.in_valid = 1'b1; b.in_data = w; fault_b = flt;
    @(negedge clk);
    b.in_valid = 1'b0;
    n = 0; seq = '0;
    while (b.shift_en && n < 10) begin seq = {seq[0], b.ser_out}; n++; @(negedge clk); end
    ed = flt ? 1'b0 : w;
    chk("b_shift_cycles", n, 2);
    chk("b_ser_out_seq", seq, {w, 1'b0});
    chk("b_out_valid", b.out_valid, 1);
    chk("b_out_data", b.out_data, ed);
    chk("b_out_match", b.out_match, (ed == w));
    b.out_ready = 1'b1;
    @(negedge clk);
    b.out_ready = 1'b0; fault_b = 1'b0;
    chk("b_back_to_idle", b.in_ready, 1);
  endtask

  task automatic b2b_a();
    logic [7:0] lst [3];
    int idx, t;
    lst = '{8'h00, 8'hFF, 8'h5A};
    acc_a.delete(); outd_a.delete(); outm_a.delete();
    a.out_ready = 1'b1; idx = 0; t = 0;
    while (t < 100) begin
      if (a.in_ready) begin
        if (idx == 3) break;
        a.in_data = lst[idx]; a.in_valid = 1'b1; idx++;
      end else a.in_valid = 1'b0;
      @(negedge clk); t++;
    end
    a.in_valid = 1'b0; a.out_ready = 1'b0;
    chk("a_b2b_accepts", acc_a.size(), 3);
    chk("a_b2b_outputs", outd_a.size(), 3);
    for (int i = 1; i < acc_a.size(); i++) chk("a_b2b_period", acc_a[i] - acc_a[i-1], 14);
    for (int i = 0; i < outd_a.size() && i < 3; i++) begin
      chk("a_b2b_data", outd_a[i], lst[i]);
      chk("a_b2b_match", outm_a[i], 1);
    end
  endtask

  task automatic b2b_b();
    logic lst [4];
    int idx, t;
    lst = '{1'b0, 1'b1, 1'b1, 1'b0};
    acc_b.delete(); outd_b.delete(); outm_b.delete();
    b.out_ready = 1'b1; idx = 0; t = 0;
    while (t < 60) begin
      if (b.in_ready) begin
        if (idx == 4) break;
        b.in_data = lst[idx]; b.in_valid = 1'b1; idx++;
      end else b.in_valid = 1'b0;
      @(negedge clk); t++;
    end
    b.in_valid = 1'b0; b.out_ready = 1'b0;
    chk("b_b2b_accepts", acc_b.size(), 4);
    for (int i = 1; i < acc_b.size(); i++) chk("b_b2b_period", acc_b[i] - acc_b[i-1], 4);
    for (int i = 0; i < outd_b.size() && i < 4; i++) begin
      chk("b_b2b_data", outd_b[i], lst[i]);
      chk("b_b2b_match", outm_b[i], 1);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    logic [7:0] w, ed;
    bit flt;
    a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;

    tbl[0] = '{8'hA5, 1'b0, 0, 8'hA5, 1'b1};
    tbl[1] = '{8'h3C, 1'b1, 0, 8'h00, 1'b0};
    tbl[2] = '{8'hC3, 1'b0, 7, 8'hC3, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 2, 8'h00, 1'b1};
    tbl[4] = '{8'hFF, 1'b0, 1, 8'hFF, 1'b1};
    tbl[5] = '{8'h01, 1'b1, 3, 8'h00, 1'b0};

    // Reset pulse placed mid-clock; outputs checked while reset is still high.
    #2 reset = 1'b1;
    #6;
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_shift_en", a.shift_en, 0);
    chk("rst_ser_out", a.ser_out, 0);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_out_match", a.out_match, 0);
    chk("rst_state", 32'(dut_a.state_q), 32'(IDLE));
    chk("rst_b_in_ready", b.in_ready, 1);
    #4 reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      send_a(tbl[i].word, tbl[i].flt, tbl[i].stall, tbl[i].exp_data, tbl[i].exp_match);

    // Reset in the middle of a frame, then a clean frame over a stale chain.
    a.in_valid = 1'b1; a.in_data = 8'hFF;
    @(negedge clk);
    a.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_shift_active", a.shift_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", a.in_ready, 1);
    chk("mid_rst_shift_en", a.shift_en, 0);
    chk("mid_rst_ser_out", a.ser_out, 0);
    chk("mid_rst_out_valid", a.out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    send_a(8'h81, 1'b0, 0, 8'h81, 1'b1);

    b2b_a();

    // Random frames: a clean loopback returns the word; a stuck-low link returns zero.
    for (int i = 0; i < 24; i++) begin
      w   = 8'($urandom);
      flt = ($urandom_range(0, 4) == 0);
      ed  = flt ? 8'h00 : w;
      send_a(w, flt, int'($urandom_range(0, 3)), ed, (ed == w));
    end

    for (int i = 0; i < 4; i++) send_b(1'(i), i[1]);
    b2b_b();
    for (int i = 0; i < 8; i++) send_b(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
